// File: rtl/bp_fe_queue_ckpt_pkg.sv
// Shared constants for the FE->BE checkpointing queue.
package bp_fe_queue_ckpt_pkg;

    localparam int unsigned fe_queue_width_lp = 128;
    localparam int unsigned fe_queue_els_lp   = 8;

endpackage

// File: rtl/bp_fe_queue_ckpt_ptr.sv
// Wrap-bit pointer register with increment enable and a higher-priority synchronous load.
module bp_fe_queue_ckpt_ptr #(
    parameter int unsigned width_p = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    input  logic               load,
    input  logic [width_p-1:0] load_val,
    output logic [width_p-1:0] ptr,
    output logic [width_p-1:0] ptr_next
);

    logic [width_p-1:0] ptr_q;

    always_comb begin
        ptr_next = load ? load_val : ptr_q + width_p'(inc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_next;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/bp_fe_queue_ckpt.sv
// Checkpointing FIFO from FE to BE: write, speculative read and commit pointers allow
// the BE to flush unread entries or replay read-but-uncommitted ones without refetching.
module bp_fe_queue_ckpt
    import bp_fe_queue_ckpt_pkg::*;
#(
    parameter int unsigned els_p   = fe_queue_els_lp,
    parameter int unsigned width_p = fe_queue_width_lp
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] fe_queue_i,
    input  logic               fe_queue_v_i,
    output logic               fe_queue_ready_o,
    output logic [width_p-1:0] fe_queue_o,
    output logic               fe_queue_v_o,
    input  logic               fe_queue_yumi_i,
    input  logic               fe_queue_clr_i,
    input  logic               fe_queue_deq_i,
    input  logic               fe_queue_roll_i,
    output logic               empty_o
);

    localparam int unsigned ptr_width_lp = $clog2(els_p) + 1;
    localparam int unsigned idx_width_lp = ptr_width_lp - 1;

    logic [ptr_width_lp-1:0] wptr, rptr, cptr;
    logic [ptr_width_lp-1:0] wptr_next, rptr_next, cptr_next;
    logic                    full;
    logic                    enq, yumi_ok, deq_ok;

    logic [width_p-1:0] mem [els_p];

    assign full = (wptr[idx_width_lp-1:0] == cptr[idx_width_lp-1:0])
                & (wptr[ptr_width_lp-1] != cptr[ptr_width_lp-1]);

    assign fe_queue_ready_o = ~full;
    assign fe_queue_v_o     = (rptr != wptr);
    assign empty_o          = (cptr == wptr);
    assign fe_queue_o       = mem[rptr[idx_width_lp-1:0]];

    // Illegal yumi/deq are dropped here so pointers never leave the invariant.
    assign enq     = fe_queue_v_i & ~full;
    assign yumi_ok = fe_queue_yumi_i & fe_queue_v_o;
    assign deq_ok  = fe_queue_deq_i & (cptr != rptr);

    bp_fe_queue_ckpt_ptr #(.width_p(ptr_width_lp)) u_cptr (
        .clk      (clk_i),
        .rst_n    (reset_i),
        .inc      (deq_ok),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (cptr),
        .ptr_next (cptr_next)
    );

    // Roll rewinds to the checkpoint as updated by this cycle's deq.
    bp_fe_queue_ckpt_ptr #(.width_p(ptr_width_lp)) u_rptr (
        .clk      (clk_i),
        .rst_n    (reset_i),
        .inc      (yumi_ok),
        .load     (fe_queue_roll_i),
        .load_val (cptr_next),
        .ptr      (rptr),
        .ptr_next (rptr_next)
    );

    // Clear truncates to the read pointer as updated by this cycle's yumi/roll.
    bp_fe_queue_ckpt_ptr #(.width_p(ptr_width_lp)) u_wptr (
        .clk      (clk_i),
        .rst_n    (reset_i),
        .inc      (enq),
        .load     (fe_queue_clr_i),
        .load_val (rptr_next),
        .ptr      (wptr),
        .ptr_next (wptr_next)
    );

    always_ff @(posedge clk_i) begin
        if (enq && !fe_queue_clr_i) begin
            mem[wptr[idx_width_lp-1:0]] <= fe_queue_i;
        end
    end

    a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_i)
        fe_queue_yumi_i |-> fe_queue_v_o)
        else $error("yumi with no unread entry");

    a_deq_legal: assert property (@(posedge clk_i) disable iff (!reset_i)
        fe_queue_deq_i |-> (cptr != rptr))
        else $error("deq with no read entry");

    a_occupancy: assert property (@(posedge clk_i) disable iff (!reset_i)
        ptr_width_lp'(wptr_next - cptr_next) <= ptr_width_lp'(els_p))
        else $error("occupancy exceeds capacity");

endmodule
